// File: rtl/ctrl_sequencer.sv
// ============================================================================
// ctrl_sequencer : table-driven control-word sequencer with start/done,
//                  hold and abort handshakes
// Revision       : 1.0
// ============================================================================
`default_nettype none

module ctrl_sequencer #(
  parameter int                        NUM_STEPS  = 4,
  parameter int                        CW         = 7,
  parameter int                        ITER_W     = 4,
  parameter logic [NUM_STEPS*CW-1:0]   CTRL_TABLE = {7'h00, 7'h36, 7'h12, 7'h09},
  parameter logic [CW-1:0]             IDLE_CW    = 7'h00,
  localparam int                       SW         = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_count,
  input  logic              hold,
  input  logic              abort,
  output logic [CW-1:0]     ctrl,
  output logic [SW-1:0]     step,
  output logic [ITER_W-1:0] iter_left,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [SW-1:0]     LAST_STEP = SW'(NUM_STEPS - 1);
  localparam logic [ITER_W-1:0] ONE_ITER  = ITER_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       ctrl_q, ctrl_d;
  logic [SW-1:0]       step_q, step_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  logic [CW-1:0]       w_tbl [NUM_STEPS];
  logic [SW-1:0]       w_step_inc;

  for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_tbl
    assign w_tbl[gi] = CTRL_TABLE[gi*CW +: CW];
  end

  assign w_step_inc = step_q + SW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= IDLE_CW;
      step_q    <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      step_q    <= step_d;
      iter_q    <= iter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    step_d    = step_q;
    iter_d    = iter_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN;
          step_d  = '0;
          ctrl_d  = w_tbl[0];
          busy_d  = 1'b1;
          iter_d  = (iter_count == '0) ? ONE_ITER : iter_count;
        end
      end

      S_RUN: begin
        // abort wins over hold, hold wins over advancing
        if (abort) begin
          state_d   = S_IDLE;
          ctrl_d    = IDLE_CW;
          step_d    = '0;
          iter_d    = '0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (!hold) begin
          if (step_q != LAST_STEP) begin
            step_d = w_step_inc;
            ctrl_d = w_tbl[w_step_inc];
          end else if (iter_q > ONE_ITER) begin
            step_d = '0;
            ctrl_d = w_tbl[0];
            iter_d = iter_q - ONE_ITER;
          end else begin
            state_d = S_DONE;
            step_d  = '0;
            ctrl_d  = IDLE_CW;
            iter_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        ctrl_d  = IDLE_CW;
        step_d  = '0;
        iter_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign ctrl      = ctrl_q;
  assign step      = step_q;
  assign iter_left = iter_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

`default_nettype wire
